// File: rtl/sha256_pkg.sv
// Shared constants and helpers for the SHA-256 message sequencer.
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int BLK_WORDS = 16;
    localparam int BLK_W     = WORD_W * BLK_WORDS;
    localparam int DIG_W     = 256;
    localparam int LEN_W     = 64;

    typedef logic [WORD_W-1:0] word_t;

    // Word holding the single mandatory '1' bit when the message ends on a word boundary
    localparam word_t PAD_WORD = 32'h8000_0000;
    // Block position where the 64-bit length field begins
    localparam logic [3:0] LEN_IDX = 4'd14;

    // Sequencer FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_PAD   = 3'd2;
    localparam logic [2:0] ST_LEN   = 3'd3;
    localparam logic [2:0] ST_ISSUE = 3'd4;
    localparam logic [2:0] ST_WAIT  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    // Number of message bits carried by a word with the given byte count (0 means a full word)
    function automatic logic [6:0] byte_bits(input logic [1:0] nbytes);
        return (nbytes == 2'd0) ? 7'd32 : {2'b00, nbytes, 3'b000};
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Final-word formatter: keeps the valid leading bytes, zeroes the rest and
// places the 0x80 terminator right after the last valid byte. A full word
// passes through untouched (its terminator goes into the following word).
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] data_i,
    input  logic [1:0]        bytes_i,
    output logic [WORD_W-1:0] word_o
);

    // Mask and terminate according to the number of valid bytes
    always_comb begin
        case (bytes_i)
            2'd1:    word_o = {data_i[31:24], 24'h80_0000};
            2'd2:    word_o = {data_i[31:16], 16'h8000};
            2'd3:    word_o = {data_i[31:8],  8'h80};
            default: word_o = data_i;
        endcase
    end

endmodule

// File: rtl/sha256_msg_sequencer.sv
// SHA-256 front end: collects 32-bit big-endian message words, appends the
// padding and 64-bit bit-length, hands 512-bit blocks to the core one at a
// time and holds the final digest until the consumer takes it.
module sha256_msg_sequencer
    import sha256_pkg::*;
#(
    parameter int len_width_p  = 64,
    parameter int word_width_p = 32
)
(
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    en_i,
    input  logic                    msg_v_i,
    input  logic [word_width_p-1:0] msg_data_i,
    input  logic                    msg_last_i,
    input  logic [1:0]              msg_bytes_i,
    output logic                    msg_ready_o,
    output logic                    blk_v_o,
    output logic [BLK_W-1:0]        blk_data_o,
    output logic                    blk_first_o,
    input  logic                    blk_ready_i,
    input  logic                    dig_v_i,
    input  logic [DIG_W-1:0]        dig_i,
    output logic                    digest_v_o,
    output logic [DIG_W-1:0]        digest_o,
    input  logic                    digest_yumi_i,
    output logic                    busy_o
);

    logic [2:0]             state_q, state_d;
    logic [2:0]             ret_q, ret_d;      // where to resume after the core finishes a non-final block
    logic [3:0]             idx_q, idx_d;
    logic                   first_q, first_d;
    logic                   final_q, final_d;
    logic                   pend_q, pend_d;    // full last word seen, PAD_WORD still to be written
    logic [len_width_p-1:0] bitlen_q, bitlen_d;
    logic [DIG_W-1:0]       digest_q, digest_d;
    word_t                  buf_q [BLK_WORDS];

    logic                   wr_en;
    word_t                  wr_data;
    logic                   len_wr;
    word_t                  pad_word;

    sha256_pad_word u_pad_word (
        .data_i  (msg_data_i),
        .bytes_i (msg_bytes_i),
        .word_o  (pad_word)
    );

    // Next-state logic: nothing advances while en_i is low
    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        idx_d    = idx_q;
        first_d  = first_q;
        final_d  = final_q;
        pend_d   = pend_q;
        bitlen_d = bitlen_q;
        digest_d = digest_q;
        wr_en    = 1'b0;
        wr_data  = '0;
        len_wr   = 1'b0;
        if (en_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (msg_v_i) begin
                        state_d  = ST_FILL;
                        idx_d    = 4'd0;
                        bitlen_d = '0;
                        first_d  = 1'b1;
                        final_d  = 1'b0;
                        pend_d   = 1'b0;
                    end
                end
                ST_FILL: begin
                    if (msg_v_i) begin
                        wr_en = 1'b1;
                        idx_d = idx_q + 4'd1;
                        if (msg_last_i) begin
                            wr_data  = pad_word;
                            bitlen_d = bitlen_q + len_width_p'(byte_bits(msg_bytes_i));
                            pend_d   = (msg_bytes_i == 2'd0);
                            if (idx_q == 4'd15) begin
                                state_d = ST_ISSUE;
                                ret_d   = ST_PAD;
                            end else begin
                                state_d = ST_PAD;
                            end
                        end else begin
                            wr_data  = msg_data_i;
                            bitlen_d = bitlen_q + len_width_p'(32);
                            if (idx_q == 4'd15) begin
                                state_d = ST_ISSUE;
                                ret_d   = ST_FILL;
                            end
                        end
                    end
                end
                ST_PAD: begin
                    // Terminator first (if owed), then zeros up to the length slot
                    if (pend_q || (idx_q != LEN_IDX)) begin
                        wr_en   = 1'b1;
                        wr_data = pend_q ? PAD_WORD : '0;
                        pend_d  = 1'b0;
                        idx_d   = idx_q + 4'd1;
                        if (idx_q == 4'd15) begin
                            state_d = ST_ISSUE;
                            ret_d   = ST_PAD;
                        end
                    end else begin
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    len_wr  = 1'b1;
                    idx_d   = 4'd0;
                    final_d = 1'b1;
                    state_d = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (blk_ready_i) begin
                        first_d = 1'b0;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dig_v_i) begin
                        if (final_q) begin
                            digest_d = dig_i;
                            state_d  = ST_DONE;
                        end else begin
                            state_d  = ret_q;
                        end
                    end
                end
                ST_DONE: begin
                    if (digest_yumi_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control and length registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            ret_q    <= ST_FILL;
            idx_q    <= '0;
            first_q  <= 1'b0;
            final_q  <= 1'b0;
            pend_q   <= 1'b0;
            bitlen_q <= '0;
            digest_q <= '0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            idx_q    <= idx_d;
            first_q  <= first_d;
            final_q  <= final_d;
            pend_q   <= pend_d;
            bitlen_q <= bitlen_d;
            digest_q <= digest_d;
        end
    end

    // Block buffer: one word per cycle from FILL/PAD, both length words at once from LEN
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < BLK_WORDS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                buf_q[idx_q] <= wr_data;
            end
            if (len_wr) begin
                buf_q[14] <= bitlen_q[len_width_p-1:32];
                buf_q[15] <= bitlen_q[31:0];
            end
        end
    end

    // Word 0 lands in the most significant slice of the block bus
    for (genvar gi = 0; gi < BLK_WORDS; gi++) begin : g_flat
        assign blk_data_o[BLK_W-1-WORD_W*gi -: WORD_W] = buf_q[gi];
    end

    assign msg_ready_o = (state_q == ST_FILL);
    assign blk_v_o     = (state_q == ST_ISSUE);
    assign blk_first_o = blk_v_o & first_q;
    assign digest_v_o  = (state_q == ST_DONE);
    assign digest_o    = digest_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Directed bench for sha256_msg_sequencer; the bench plays both the word
// source and the compression core.
module tb_sha256_msg_sequencer;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic         en_i;
    logic         msg_v_i;
    logic [31:0]  msg_data_i;
    logic         msg_last_i;
    logic [1:0]   msg_bytes_i;
    logic         msg_ready_o;
    logic         blk_v_o;
    logic [511:0] blk_data_o;
    logic         blk_first_o;
    logic         blk_ready_i;
    logic         dig_v_i;
    logic [255:0] dig_i;
    logic         digest_v_o;
    logic [255:0] digest_o;
    logic         digest_yumi_i;
    logic         busy_o;

    int total = 0;
    int bad   = 0;

    localparam logic [255:0] GOLD = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D2   = 256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0001;
    localparam logic [255:0] D3   = 256'h0f0e0d0c_0b0a0908_07060504_03020100_deadbeef_cafef00d_01234567_89abcdef;
    localparam logic [255:0] D4   = 256'h55aa55aa_aa55aa55_12345678_9abcdef0_0fedcba9_87654321_a5a5a5a5_5a5a5a5a;
    localparam logic [255:0] JUNK = 256'hbad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0;

    sha256_msg_sequencer dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .en_i          (en_i),
        .msg_v_i       (msg_v_i),
        .msg_data_i    (msg_data_i),
        .msg_last_i    (msg_last_i),
        .msg_bytes_i   (msg_bytes_i),
        .msg_ready_o   (msg_ready_o),
        .blk_v_o       (blk_v_o),
        .blk_data_o    (blk_data_o),
        .blk_first_o   (blk_first_o),
        .blk_ready_i   (blk_ready_i),
        .dig_v_i       (dig_v_i),
        .dig_i         (dig_i),
        .digest_v_o    (digest_v_o),
        .digest_o      (digest_o),
        .digest_yumi_i (digest_yumi_i),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_pat(input int w);
        return {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
    endfunction

    // Block whose first nw words carry the byte-counting pattern, rest zero
    function automatic logic [511:0] data_block(input int nw);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < nw; i++) begin
            b[511-32*i -: 32] = word_pat(i);
        end
        return b;
    endfunction

    task automatic send_word(input logic [31:0] data, input logic last, input logic [1:0] nbytes);
        int n;
        n = 0;
        msg_v_i     = 1'b1;
        msg_data_i  = data;
        msg_last_i  = last;
        msg_bytes_i = nbytes;
        while (!(msg_ready_o && en_i) && n < 50) begin
            tick();
            n++;
        end
        chk("msg_ready_wait", {511'd0, msg_ready_o}, 512'd1);
        tick();
        msg_v_i    = 1'b0;
        msg_last_i = 1'b0;
    endtask

    task automatic send_msg(input int nwords, input logic [1:0] lastbytes);
        for (int w = 0; w < nwords; w++) begin
            send_word(word_pat(w), (w == nwords-1), lastbytes);
        end
    endtask

    task automatic take_block(output logic [511:0] d, output logic f);
        int n;
        n = 0;
        while (!blk_v_o && n < 100) begin
            tick();
            n++;
        end
        chk("blk_v_wait", {511'd0, blk_v_o}, 512'd1);
        d = blk_data_o;
        f = blk_first_o;
        blk_ready_i = 1'b1;
        tick();
        blk_ready_i = 1'b0;
        $display("block accepted: first=%0b w0=%08h w13=%08h w14=%08h w15=%08h",
                 f, d[511:480], d[95:64], d[63:32], d[31:0]);
    endtask

    task automatic give_dig(input logic [255:0] d);
        tick();
        tick();
        dig_v_i = 1'b1;
        dig_i   = d;
        tick();
        dig_v_i = 1'b0;
    endtask

    task automatic take_digest(input string tag, input logic [255:0] exp);
        int n;
        n = 0;
        while (!digest_v_o && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_digest_v"}, {511'd0, digest_v_o}, 512'd1);
        chk({tag, "_digest"}, {256'd0, digest_o}, {256'd0, exp});
        chk({tag, "_ready_in_done"}, {511'd0, msg_ready_o}, 512'd0);
        digest_yumi_i = 1'b1;
        tick();
        digest_yumi_i = 1'b0;
        chk({tag, "_idle_after_yumi"}, {511'd0, busy_o}, 512'd0);
        $display("digest taken: %s %064h", tag, exp);
    endtask

    initial begin
        logic [511:0] blk;
        logic [511:0] exp;
        logic [511:0] held;
        logic         first;

        reset_n_i     = 1'b0;
        en_i          = 1'b1;
        msg_v_i       = 1'b0;
        msg_data_i    = '0;
        msg_last_i    = 1'b0;
        msg_bytes_i   = '0;
        blk_ready_i   = 1'b0;
        dig_v_i       = 1'b0;
        dig_i         = '0;
        digest_yumi_i = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_busy",    {511'd0, busy_o},      512'd0);
        chk("rst_ready",   {511'd0, msg_ready_o}, 512'd0);
        chk("rst_blk_v",   {511'd0, blk_v_o},     512'd0);
        chk("rst_first",   {511'd0, blk_first_o}, 512'd0);
        chk("rst_dig_v",   {511'd0, digest_v_o},  512'd0);
        chk("rst_blk",     blk_data_o,            512'd0);
        chk("rst_digest",  {256'd0, digest_o},    512'd0);
        reset_n_i = 1'b1;
        tick();

        // "abc": single block, length 24 bits
        send_word(32'h6162_6300, 1'b1, 2'd3);
        take_block(blk, first);
        exp = '0;
        exp[511:480] = 32'h6162_6380;
        exp[31:0]    = 32'h0000_0018;
        chk("abc_block", blk, exp);
        chk("abc_first", {511'd0, first}, 512'd1);
        chk("abc_blk_v_low_in_wait", {511'd0, blk_v_o}, 512'd0);
        give_dig(GOLD);
        take_digest("abc", GOLD);

        // 55 bytes: terminator fits in word 13, still one block (440 bits)
        send_msg(14, 2'd3);
        take_block(blk, first);
        exp = data_block(13);
        exp[95:64] = 32'h3435_3680;
        exp[31:0]  = 32'h0000_01b8;
        chk("b55_block", blk, exp);
        chk("b55_first", {511'd0, first}, 512'd1);
        give_dig(D2);
        take_digest("b55", D2);

        // 56 bytes: length no longer fits, spills into a second block (448 bits)
        send_msg(14, 2'd0);
        take_block(blk, first);
        exp = data_block(14);
        exp[63:32] = 32'h8000_0000;
        chk("b56_block1", blk, exp);
        chk("b56_first1", {511'd0, first}, 512'd1);
        give_dig(JUNK);
        chk("b56_no_digest_mid", {511'd0, digest_v_o}, 512'd0);
        chk("b56_busy_mid", {511'd0, busy_o}, 512'd1);
        take_block(blk, first);
        exp = '0;
        exp[31:0] = 32'h0000_01c0;
        chk("b56_block2", blk, exp);
        chk("b56_first2", {511'd0, first}, 512'd0);
        give_dig(D3);
        take_digest("b56", D3);

        // 64 bytes with the core stalling the first block for 5 cycles
        send_msg(16, 2'd0);
        chk("b64_issue_latency", {511'd0, blk_v_o}, 512'd1);
        held = blk_data_o;
        for (int c = 0; c < 5; c++) begin
            msg_v_i    = 1'b1;
            msg_data_i = 32'hfeed_f00d;
            tick();
            chk("b64_stall_blk_v",  {511'd0, blk_v_o},     512'd1);
            chk("b64_stall_data",   blk_data_o,            held);
            chk("b64_stall_ready",  {511'd0, msg_ready_o}, 512'd0);
        end
        msg_v_i = 1'b0;
        take_block(blk, first);
        chk("b64_block1", blk, data_block(16));
        chk("b64_first1", {511'd0, first}, 512'd1);
        give_dig(JUNK);
        take_block(blk, first);
        exp = '0;
        exp[511:480] = 32'h8000_0000;
        exp[31:0]    = 32'h0000_0200;
        chk("b64_block2", blk, exp);
        chk("b64_first2", {511'd0, first}, 512'd0);
        give_dig(D4);
        // Consumer holds off for 10 cycles while a new word and a stray digest pulse arrive
        for (int c = 0; c < 10; c++) begin
            msg_v_i    = 1'b1;
            msg_data_i = 32'h0bad_0bad;
            dig_v_i    = (c == 4);
            dig_i      = JUNK;
            tick();
            chk("b64_hold_dig_v", {511'd0, digest_v_o},  512'd1);
            chk("b64_hold_dig",   {256'd0, digest_o},    {256'd0, D4});
            chk("b64_hold_ready", {511'd0, msg_ready_o}, 512'd0);
        end
        msg_v_i       = 1'b0;
        dig_v_i       = 1'b0;
        digest_yumi_i = 1'b1;
        tick();
        digest_yumi_i = 1'b0;
        chk("b64_after_yumi_busy",  {511'd0, busy_o},     512'd0);
        chk("b64_after_yumi_dig_v", {511'd0, digest_v_o}, 512'd0);
        $display("digest taken: b64 %064h", D4);

        // Reset in the middle of filling (7 words stored)
        for (int w = 0; w < 7; w++) begin
            send_word(word_pat(w), 1'b0, 2'd0);
        end
        chk("midfill_busy", {511'd0, busy_o}, 512'd1);
        reset_n_i = 1'b0;
        tick();
        chk("mrst_busy",   {511'd0, busy_o},      512'd0);
        chk("mrst_ready",  {511'd0, msg_ready_o}, 512'd0);
        chk("mrst_blk_v",  {511'd0, blk_v_o},     512'd0);
        chk("mrst_first",  {511'd0, blk_first_o}, 512'd0);
        chk("mrst_dig_v",  {511'd0, digest_v_o},  512'd0);
        chk("mrst_blk",    blk_data_o,            512'd0);
        chk("mrst_digest", {256'd0, digest_o},    512'd0);
        reset_n_i = 1'b1;
        tick();

        // Fresh "abc" (junk in the masked byte) with en_i stalls in WAIT and DONE
        send_word(32'h6162_63ee, 1'b1, 2'd3);
        take_block(blk, first);
        exp = '0;
        exp[511:480] = 32'h6162_6380;
        exp[31:0]    = 32'h0000_0018;
        chk("abc2_block", blk, exp);
        chk("abc2_first", {511'd0, first}, 512'd1);
        en_i    = 1'b0;
        dig_v_i = 1'b1;
        dig_i   = GOLD;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("en_stall_dig_v", {511'd0, digest_v_o}, 512'd0);
            chk("en_stall_busy",  {511'd0, busy_o},     512'd1);
            chk("en_stall_blk_v", {511'd0, blk_v_o},    512'd0);
        end
        en_i = 1'b1;
        tick();
        dig_v_i = 1'b0;
        chk("en_resume_dig_v", {511'd0, digest_v_o}, 512'd1);
        chk("en_resume_dig",   {256'd0, digest_o},   {256'd0, GOLD});
        en_i          = 1'b0;
        digest_yumi_i = 1'b1;
        tick();
        chk("en_yumi_blocked", {511'd0, digest_v_o}, 512'd1);
        en_i = 1'b1;
        tick();
        digest_yumi_i = 1'b0;
        chk("en_yumi_taken", {511'd0, digest_v_o}, 512'd0);
        chk("en_yumi_idle",  {511'd0, busy_o},     512'd0);
        $display("digest taken: abc2 %064h", GOLD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
